// File: rtl/rs_symbol_fifo.sv
// Word-in, symbol-out transmit queue: DEPTH words, one symbol per pop, 1-cycle push-to-output.
// Push while full is dropped (sticky overflow); pop while empty is ignored (sticky underflow).
module rs_symbol_fifo #(
  parameter int SYM_W     = 8,
  parameter int SYMS      = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [SYM_W*SYMS-1:0]      word_in,
  input  logic                       pop,
  output logic [SYM_W-1:0]           sym_out,
  output logic                       sym_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] word_count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int W  = SYM_W * SYMS;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (SYMS > 1) ? $clog2(SYMS) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [IW-1:0]    r_sym_idx;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_last_sym;
  logic             w_retire;
  logic [W-1:0]     w_head;
  logic [SYM_W-1:0] w_sym;

  // Full/empty come from registered count only, so a same-cycle retire never frees a slot for push.
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_push_ok  = push && !w_full;
  assign w_pop_ok   = pop && !w_empty;
  assign w_last_sym = (r_sym_idx == IW'(SYMS - 1));
  assign w_retire   = w_pop_ok && w_last_sym;

  always_ff @(posedge clk) begin
    if (w_push_ok && !flush) begin
      r_mem[r_wr_ptr] <= word_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_sym_idx   <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_sym_idx   <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) begin
        if (w_last_sym) begin
          r_sym_idx <= '0;
          r_rd_ptr  <= r_rd_ptr + PW'(1);
        end else begin
          r_sym_idx <= r_sym_idx + IW'(1);
        end
      end
      case ({w_push_ok, w_retire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (push && w_full) begin
        r_overflow <= 1'b1;
      end
      if (pop && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_sym = '0;
    for (int i = 0; i < SYMS; i++) begin
      if (r_sym_idx == IW'(i)) begin
        w_sym = MSB_FIRST ? w_head[W-1-i*SYM_W -: SYM_W] : w_head[i*SYM_W +: SYM_W];
      end
    end
  end

  assign sym_out    = w_empty ? '0 : w_sym;
  assign sym_valid  = !w_empty;
  assign empty      = w_empty;
  assign full       = w_full;
  assign word_count = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_rs_symbol_fifo.sv
// Bench for rs_symbol_fifo: default MSB-first instance plus an LSB-first instance.
module tb_rs_symbol_fifo;

  localparam int SYM_W = 8;
  localparam int SYMS  = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, push = 1'b0, pop = 1'b0;
  logic [63:0] word_in = '0;
  logic [7:0]  sym_out;
  logic        sym_valid, empty, full, overflow, underflow;
  logic [2:0]  word_count;

  logic        flush1 = 1'b0, push1 = 1'b0, pop1 = 1'b0;
  logic [63:0] word1 = '0;
  logic [7:0]  sym_out1;
  logic        sym_valid1, empty1, full1, overflow1, underflow1;
  logic [2:0]  word_count1;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       eo = 1'b0;
  logic       eu = 1'b0;

  always #5 clk = ~clk;

  rs_symbol_fifo #(.SYM_W(SYM_W), .SYMS(SYMS), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .word_in(word_in), .pop(pop),
    .sym_out(sym_out), .sym_valid(sym_valid), .empty(empty), .full(full),
    .word_count(word_count), .overflow(overflow), .underflow(underflow)
  );

  rs_symbol_fifo #(.SYM_W(SYM_W), .SYMS(SYMS), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .push(push1), .word_in(word1), .pop(pop1),
    .sym_out(sym_out1), .sym_valid(sym_valid1), .empty(empty1), .full(full1),
    .word_count(word_count1), .overflow(overflow1), .underflow(underflow1)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mk(input logic [7:0] base);
    logic [63:0] w;
    for (int s = 0; s < SYMS; s++) w[63-8*s -: 8] = base + 8'(s);
    return w;
  endfunction

  // One clock of stimulus; the scoreboard queue tracks expected symbols in output order.
  task automatic cyc(input logic f, input logic p, input logic [63:0] w, input logic q);
    int nw;
    flush = f; push = p; word_in = w; pop = q;
    nw = (exp_q.size() + SYMS - 1) / SYMS;
    @(posedge clk);
    if (f) begin
      exp_q.delete(); eo = 1'b0; eu = 1'b0;
    end else begin
      if (q) begin
        if (exp_q.size() == 0) eu = 1'b1;
        else void'(exp_q.pop_front());
      end
      if (p) begin
        if (nw == DEPTH) eo = 1'b1;
        else for (int s = 0; s < SYMS; s++) exp_q.push_back(w[63-8*s -: 8]);
      end
    end
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({empty, full, sym_valid, overflow, underflow} !== 5'b10000) begin
      failures++; $display("FAIL reset_flags got=%b exp=10000", {empty, full, sym_valid, overflow, underflow});
    end
    checks++;
    if ({word_count, sym_out} !== 11'd0) begin
      failures++; $display("FAIL reset_count_sym got=%0d/%h exp=0/00", word_count, sym_out);
    end
    checks++;
    if ({empty1, sym_valid1} !== 2'b10) begin
      failures++; $display("FAIL reset_lsb got=%b exp=10", {empty1, sym_valid1});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_msb_first;
    cyc(1'b0, 1'b1, 64'hFF00FF00FF00FF00, 1'b0);
    checks++;
    if (word_count !== 3'd1) begin
      failures++; $display("FAIL msb_count got=%0d exp=1", word_count);
    end
    for (int i = 0; i < SYMS; i++) begin
      checks++;
      if ({sym_valid, sym_out} !== {1'b1, ((i % 2) == 0) ? 8'hFF : 8'h00}) begin
        failures++; $display("FAIL msb_sym%0d got=%b/%h exp=1/%h", i, sym_valid, sym_out, ((i % 2) == 0) ? 8'hFF : 8'h00);
      end
      cyc(1'b0, 1'b0, 64'd0, 1'b1);
    end
    checks++;
    if ({empty, sym_valid, underflow} !== 3'b100) begin
      failures++; $display("FAIL msb_drained got=%b exp=100", {empty, sym_valid, underflow});
    end
  endtask

  task automatic test_lsb_first;
    logic [7:0] lsb_exp [8] = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    push1 = 1'b1; word1 = 64'h0102030405060708;
    @(posedge clk); #1;
    push1 = 1'b0; pop1 = 1'b1;
    for (int i = 0; i < SYMS; i++) begin
      checks++;
      if ({sym_valid1, sym_out1} !== {1'b1, lsb_exp[i]}) begin
        failures++; $display("FAIL lsb_sym%0d got=%b/%h exp=1/%h", i, sym_valid1, sym_out1, lsb_exp[i]);
      end
      @(posedge clk); #1;
    end
    pop1 = 1'b0;
    checks++;
    if ({empty1, sym_valid1, underflow1} !== 3'b100) begin
      failures++; $display("FAIL lsb_drained got=%b exp=100", {empty1, sym_valid1, underflow1});
    end
  endtask

  task automatic test_overflow;
    int guard = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b1, mk(8'(16 * k)), 1'b0);
      if (k == 3) begin
        checks++;
        if ({full, overflow, word_count} !== {1'b1, 1'b0, 3'd4}) begin
          failures++; $display("FAIL ovf_full4 got=%b/%b/%0d exp=1/0/4", full, overflow, word_count);
        end
      end
    end
    checks++;
    if ({full, overflow, word_count} !== {1'b1, 1'b1, 3'd4}) begin
      failures++; $display("FAIL ovf_drop5 got=%b/%b/%0d exp=1/1/4", full, overflow, word_count);
    end
    repeat (SYMS - 1) cyc(1'b0, 1'b0, 64'd0, 1'b1);
    // Retire of the head coincides with a push while full: the push must still be dropped.
    cyc(1'b0, 1'b1, mk(8'hE0), 1'b1);
    checks++;
    if ({full, overflow, word_count} !== {1'b0, eo, 3'd3}) begin
      failures++; $display("FAIL ovf_retire_push got=%b/%b/%0d exp=0/%b/3", full, overflow, word_count, eo);
    end
    while (exp_q.size() > 0 && guard < 100) begin
      checks++;
      if ({sym_valid, sym_out} !== {1'b1, exp_q[0]}) begin
        failures++; $display("FAIL ovf_drain got=%b/%h exp=1/%h", sym_valid, sym_out, exp_q[0]);
      end
      cyc(1'b0, 1'b0, 64'd0, 1'b1);
      guard++;
    end
    checks++;
    if ({empty, sym_valid, guard} !== {1'b1, 1'b0, 32'd24}) begin
      failures++; $display("FAIL ovf_end got=%b/%b/%0d exp=1/0/24", empty, sym_valid, guard);
    end
  endtask

  task automatic test_underflow_flush;
    cyc(1'b0, 1'b0, 64'd0, 1'b1);
    checks++;
    if ({underflow, empty, word_count} !== {1'b1, 1'b1, 3'd0}) begin
      failures++; $display("FAIL unf_set got=%b/%b/%0d exp=1/1/0", underflow, empty, word_count);
    end
    cyc(1'b0, 1'b1, mk(8'h50), 1'b0);
    checks++;
    if ({sym_valid, sym_out} !== {1'b1, 8'h50}) begin
      failures++; $display("FAIL unf_ptrs got=%b/%h exp=1/50", sym_valid, sym_out);
    end
    cyc(1'b0, 1'b0, 64'd0, 1'b1);
    cyc(1'b0, 1'b0, 64'd0, 1'b1);
    cyc(1'b1, 1'b1, mk(8'h70), 1'b1);
    checks++;
    if ({overflow, underflow, empty, word_count} !== {1'b0, 1'b0, 1'b1, 3'd0}) begin
      failures++; $display("FAIL flush_clear got=%b/%b/%b/%0d exp=0/0/1/0", overflow, underflow, empty, word_count);
    end
    cyc(1'b0, 1'b1, mk(8'h60), 1'b0);
    checks++;
    if ({sym_valid, sym_out, word_count} !== {1'b1, 8'h60, 3'd1}) begin
      failures++; $display("FAIL flush_restart got=%b/%h/%0d exp=1/60/1", sym_valid, sym_out, word_count);
    end
  endtask

  task automatic test_back_to_back;
    cyc(1'b1, 1'b0, 64'd0, 1'b0);
    for (int t = 0; t <= 96; t++) begin
      cyc(1'b0, (t % 8 == 0) && (t < 96), mk(8'(t)), t > 0);
      if (t < 96) begin
        checks++;
        if ({sym_valid, full, sym_out} !== {1'b1, 1'b0, 8'(t)}) begin
          failures++; $display("FAIL b2b_t%0d got=%b/%b/%h exp=1/0/%h", t, sym_valid, full, sym_out, 8'(t));
        end
      end
    end
    checks++;
    if ({empty, sym_valid, underflow, overflow} !== 4'b1000) begin
      failures++; $display("FAIL b2b_end got=%b exp=1000", {empty, sym_valid, underflow, overflow});
    end
  endtask

  task automatic test_async_reset;
    cyc(1'b1, 1'b0, 64'd0, 1'b0);
    cyc(1'b0, 1'b1, mk(8'hA0), 1'b0);
    cyc(1'b0, 1'b1, mk(8'hB0), 1'b1);
    cyc(1'b0, 1'b0, 64'd0, 1'b1);
    cyc(1'b0, 1'b0, 64'd0, 1'b1);
    pop = 1'b0;
    checks++;
    if ({sym_out, word_count} !== {8'hA3, 3'd2}) begin
      failures++; $display("FAIL arst_pre got=%h/%0d exp=a3/2", sym_out, word_count);
    end
    #3 rst_n = 1'b0;
    #1;
    exp_q.delete(); eo = 1'b0; eu = 1'b0;
    checks++;
    if ({empty, full, sym_valid, overflow, underflow, word_count, sym_out} !== {5'b10000, 3'd0, 8'h00}) begin
      failures++; $display("FAIL arst_now got=%b/%0d/%h exp=10000/0/00",
                           {empty, full, sym_valid, overflow, underflow}, word_count, sym_out);
    end
    @(negedge clk) rst_n = 1'b1;
    cyc(1'b0, 1'b1, mk(8'hC0), 1'b0);
    checks++;
    if ({sym_valid, sym_out, word_count} !== {1'b1, 8'hC0, 3'd1}) begin
      failures++; $display("FAIL arst_restart got=%b/%h/%0d exp=1/c0/1", sym_valid, sym_out, word_count);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overflow();
    test_underflow_flush();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_symbol_fifo.md
# rs_symbol_fifo

Parametrised successor to the single-word transmit shift buffer. It queues up to DEPTH wide words from the encoder side and presents them one symbol at a time to the modulator side, in a selectable symbol order. It adds full and empty flags, a word count, sticky overflow and underflow flags, and a synchronous flush. It sits in the transmitter between the Reed-Solomon word producer and the symbol-serial modulator.

## Interface
- SYM_W, default 8: symbol width in bits.
- SYMS, default 8: symbols per word. Word width W = SYM_W*SYMS.
- DEPTH, default 4: word storage depth. Must be a power of 2 and at least 2.
- MSB_FIRST, default 1: 1 emits symbol word_in[W-1 -: SYM_W] first; 0 emits word_in[SYM_W-1:0] first.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all contents and flags.
- push  in  1  write word_in this cycle.
- word_in  in  W  word to enqueue.
- pop  in  1  consume the current symbol.
- sym_out  out  SYM_W  current symbol of the head word.
- sym_valid  out  1  sym_out holds a real symbol (equals !empty).
- empty  out  1  no words stored.
- full  out  1  DEPTH words stored.
- word_count  out  $clog2(DEPTH+1)  number of stored words, including a partially consumed head word.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop arrived while empty.

## Operation
- Storage is a DEPTH×W register array with write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH.
- A symbol index sym_idx (0..SYMS-1) selects the symbol within the head word.
- MSB_FIRST=1: sym_out = mem[rd_ptr][W-1-sym_idx*SYM_W -: SYM_W].
- MSB_FIRST=0: sym_out = mem[rd_ptr][sym_idx*SYM_W +: SYM_W].
- Push accepted (push && !full):
  - mem[wr_ptr] <= word_in.
  - wr_ptr increments.
- Push while full:
  - The word is dropped and overflow is set.
  - This holds even if the same-cycle pop retires the head word, because full is evaluated on registered state.
- Pop accepted (pop && !empty):
  - If sym_idx < SYMS-1: sym_idx increments.
  - Else: sym_idx goes to 0, rd_ptr increments, and the word is retired.
- Pop while empty: ignored; underflow is set.
- word_count:
  - +1 on an accepted push with no retire.
  - −1 on a retire with no accepted push.
  - Unchanged when both or neither occur.
- Flags: empty = (word_count==0); full = (word_count==DEPTH).
- Flush has priority over push and pop. It clears the pointers, sym_idx, word_count, overflow and underflow. Memory contents are not cleared.
- When empty, sym_out is undefined-by-contract. The implementation drives 0.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - wr_ptr, rd_ptr, sym_idx and word_count to 0.
  - overflow = 0, underflow = 0.
  - empty = 1, full = 0, sym_valid = 0, sym_out = 0.
- Reset takes effect immediately and mid-stream. Any queued or partially consumed word is lost.
- Push-to-output latency: one clock. A word pushed at edge N gives sym_valid=1 and its first symbol on sym_out after edge N. Push into empty storage has no bypass.
- Pop: sym_out advances to the next symbol after the edge on which pop is sampled high. The last symbol of a word is followed in the next cycle by the first symbol of the next word, with no bubble.
- Simultaneous push and retire with word_count==1: sym_valid stays 1 and the new word is presented next cycle.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no lost or duplicated word.
- Throughput: one symbol per clock with pop held high. A word of SYMS symbols is drained in SYMS cycles.
- All outputs are registered-state-derived. There is no combinational path from push or pop to any output.

## Test plan
- Reset, then push 64'hFF00FF00FF00FF00 (defaults) and hold pop=1 → sym_out sequence FF,00,FF,00,FF,00,FF,00 on consecutive cycles, then empty=1 and sym_valid=0.
- With MSB_FIRST=0, push 64'h0102030405060708 → sym_out sequence 08,07,06,05,04,03,02,01.
- Push 5 words back-to-back with DEPTH=4 → full=1 after the 4th push, 5th word dropped, overflow=1, word_count=4. Draining yields exactly the first 4 words in order.
- Pop while empty → underflow=1, pointers unchanged. Then flush → underflow=0, overflow=0, word_count=0.
- Continuous push every 8 cycles with pop held high for 12 words (DEPTH=4) → pointers wrap 3 times, 96 symbols out in order, never full after the first word, and no gap between words.
- Deassert rst_n asynchronously mid-word (sym_idx=3, word_count=2) → all outputs immediately return to reset values. The next push is output from symbol 0.
